// File: rtl/vga_text_pkg.sv
// Shared types and constants for the VGA text-mode RAM.
// The BANNER state exists only when VGA_TEXT_RAM_BANNER_EN is defined.
package vga_text_pkg;

  localparam int BANNER_LEN   = 27;
  localparam int BANNER_IDX_W = $clog2(BANNER_LEN);

  localparam logic [8*BANNER_LEN-1:0] BANNER_STR = "Zet processor v1.0 SOPC VDU";

`ifdef VGA_TEXT_RAM_BANNER_EN
  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_BANNER = 2'd1,
    ST_RUN    = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd2
  } state_e;
`endif

  // String literals pack the first character into the most significant byte.
  function automatic logic [7:0] banner_char(input logic [BANNER_IDX_W-1:0] idx);
    int i;
    i = int'(idx);
    if (i < BANNER_LEN) begin
      return BANNER_STR[8*(BANNER_LEN-1-i) +: 8];
    end
    return 8'h20;
  endfunction

endpackage

// File: rtl/vga_text_dpram.sv
// True dual-port text RAM: port A read/write with per-byte-lane enables,
// port B read-only. Both ports are read-first with registered, enabled outputs.
module vga_text_dpram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int NB     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_rd_en,
  input  logic [NB-1:0]     a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_en,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  always_ff @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (a_we[k]) begin
        mem[a_addr][8*k +: 8] <= a_wdata[8*k +: 8];
      end
    end
  end

  // Non-blocking writes above guarantee both readers see the pre-write word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata_q <= '0;
    end else if (a_rd_en) begin
      a_rdata_q <= mem[a_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_rdata_q <= '0;
    end else if (b_en) begin
      b_rdata_q <= mem[b_addr];
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/vga_text_ram.sv
// VGA text RAM: CPU bus port shared with a screen-fill engine, plus a never-stalled
// video read port. Define VGA_TEXT_RAM_BANNER_EN to write a banner line after clearing.
module vga_text_ram
  import vga_text_pkg::*;
#(
  parameter int                ADDR_W   = 11,
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] CLR_WORD = 16'h0720,
  localparam int               NB       = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [NB-1:0]     wb_sel,
  input  logic [ADDR_W-1:0] wb_adr,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack,
  input  logic              vid_en,
  input  logic [ADDR_W-1:0] vid_adr,
  output logic [DATA_W-1:0] vid_dat,
  input  logic              clr_req,
  output logic              busy,
  output logic [1:0]        dbg_state_o
);

  state_e            state_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_inc;
  logic              wb_ack_q;
  logic              accept;

  logic              a_rd_en;
  logic [NB-1:0]     a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;

  // Bus handshake: a request (cyc & stb) is taken in RUN on any cycle where ack
  // is low and no clear is requested; ack is high for exactly the following cycle,
  // carrying read data. The master holds the request until it sees ack.
  assign accept  = (state_q == ST_RUN) && wb_cyc && wb_stb && !wb_ack_q && !clr_req;
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_CLEAR;
      cnt_q    <= '0;
      wb_ack_q <= 1'b0;
    end else begin
      wb_ack_q <= accept;
      if (clr_req) begin
        state_q <= ST_CLEAR;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_CLEAR: begin
            // The extra counter bit carries out exactly when the last word is written.
            if (cnt_inc[ADDR_W]) begin
              cnt_q <= '0;
`ifdef VGA_TEXT_RAM_BANNER_EN
              state_q <= ST_BANNER;
`else
              state_q <= ST_RUN;
`endif
            end else begin
              cnt_q <= cnt_inc;
            end
          end
`ifdef VGA_TEXT_RAM_BANNER_EN
          ST_BANNER: begin
            if (cnt_q == (ADDR_W+1)'(BANNER_LEN - 1)) begin
              cnt_q   <= '0;
              state_q <= ST_RUN;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
`endif
          ST_RUN: begin
            cnt_q <= '0;
          end
          default: begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    a_rd_en = 1'b0;
    a_we    = '0;
    a_addr  = wb_adr;
    a_wdata = wb_dat_i;
    case (state_q)
      ST_CLEAR: begin
        a_we    = '1;
        a_addr  = cnt_q[ADDR_W-1:0];
        a_wdata = CLR_WORD;
      end
`ifdef VGA_TEXT_RAM_BANNER_EN
      ST_BANNER: begin
        a_we    = '1;
        a_addr  = cnt_q[ADDR_W-1:0];
        a_wdata = {CLR_WORD[DATA_W-1:8], banner_char(cnt_q[BANNER_IDX_W-1:0])};
      end
`endif
      ST_RUN: begin
        if (accept) begin
          a_we    = wb_we ? wb_sel : '0;
          a_rd_en = !wb_we;
        end
      end
      default: begin
        a_we = '0;
      end
    endcase
  end

  vga_text_dpram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NB     (NB)
  ) u_dpram (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_rd_en (a_rd_en),
    .a_we    (a_we),
    .a_addr  (a_addr),
    .a_wdata (a_wdata),
    .a_rdata (wb_dat_o),
    .b_en    (vid_en),
    .b_addr  (vid_adr),
    .b_rdata (vid_dat)
  );

  assign wb_ack      = wb_ack_q;
  assign busy        = (state_q != ST_RUN);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vga_text_ram.sv
// Bench for vga_text_ram: directed bus and video vectors, checked by a queue-based
// monitor. Expectations follow VGA_TEXT_RAM_BANNER_EN when it is defined.
module tb_vga_text_ram;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;
  localparam int NB     = 2;
  localparam int DEPTH  = 2048;
`ifdef VGA_TEXT_RAM_BANNER_EN
  localparam int BAN = 27;
  localparam logic [15:0] EXP_ADR0 = 16'h075A;
`else
  localparam int BAN = 0;
  localparam logic [15:0] EXP_ADR0 = 16'h0720;
`endif
  localparam int FILL = DEPTH + BAN;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wb_cyc, wb_stb, wb_we;
  logic [NB-1:0]     wb_sel;
  logic [ADDR_W-1:0] wb_adr;
  logic [DATA_W-1:0] wb_dat_i;
  logic [DATA_W-1:0] wb_dat_o;
  logic              wb_ack;
  logic              vid_en;
  logic [ADDR_W-1:0] vid_adr;
  logic [DATA_W-1:0] vid_dat;
  logic              clr_req;
  logic              busy;
  logic [1:0]        dbg_state_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic              rd_q[$];
  logic [DATA_W-1:0] vid_q[$];
  logic [DATA_W-1:0] model [DEPTH];

  logic              mon_en_prev = 1'b0;
  logic              mon_seen    = 1'b0;
  logic [DATA_W-1:0] mon_last    = '0;
  logic [DATA_W-1:0] mon_e;
  logic              mon_r;
  int                lat;
  int                n;

  vga_text_ram dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_cyc      (wb_cyc),
    .wb_stb      (wb_stb),
    .wb_we       (wb_we),
    .wb_sel      (wb_sel),
    .wb_adr      (wb_adr),
    .wb_dat_i    (wb_dat_i),
    .wb_dat_o    (wb_dat_o),
    .wb_ack      (wb_ack),
    .vid_en      (vid_en),
    .vid_adr     (vid_adr),
    .vid_dat     (vid_dat),
    .clr_req     (clr_req),
    .busy        (busy),
    .dbg_state_o (dbg_state_o)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_model();
    string ban;
    ban = "Zet processor v1.0 SOPC VDU";
    for (int i = 0; i < DEPTH; i++) model[i] = 16'h0720;
    for (int i = 0; i < BAN; i++) model[i] = {8'h07, ban[i]};
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    fill_model();
  endtask

  // Driver: one bus transaction, expectation queued for the monitor.
  task automatic xfer(input logic we, input logic [NB-1:0] sel, input logic [ADDR_W-1:0] adr,
                      input logic [DATA_W-1:0] dat, input logic [DATA_W-1:0] exp,
                      input logic clr, output int l);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_sel = sel; wb_adr = adr; wb_dat_i = dat;
    clr_req = clr;
    exp_q.push_back(exp);
    rd_q.push_back(!we);
    if (clr) fill_model();
    if (we) for (int k = 0; k < NB; k++) if (sel[k]) model[adr][8*k +: 8] = dat[8*k +: 8];
    l = 0;
    do begin
      cycle();
      l++;
      if (clr && l == 1) begin
        clr_req = 1'b0;
        check("clr_busy_rises", 32'(busy), 32'd1);
        check("clr_write_no_ack", 32'(wb_ack), 32'd0);
      end
    end while (!wb_ack && l < 5000);
    if (!wb_ack) begin
      n_tests++;
      n_fail++;
      $display("FAIL xfer_timeout: no ack at adr %0h after %0d cycles", adr, l);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_sel = '0; wb_adr = '0; wb_dat_i = '0;
    vid_en = 1'b0; vid_adr = '0; clr_req = 1'b0;
    repeat (3) cycle();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ack", 32'(wb_ack), 32'd0);
    check("rst_dat_o", 32'(wb_dat_o), 32'd0);
    check("rst_vid_dat", 32'(vid_dat), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Monitor: pops expectations whenever the DUT presents ack or video data.
    fork
      forever begin
        @(negedge clk);
        if (wb_ack) begin
          check("ack_not_busy", 32'(busy), 32'd0);
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_unexpected: ack with no pending request, dat %0h", wb_dat_o);
          end else begin
            mon_e = exp_q.pop_front();
            mon_r = rd_q.pop_front();
            if (mon_r) check("rd_data", 32'(wb_dat_o), 32'(mon_e));
          end
        end
        if (mon_en_prev) begin
          if (vid_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL vid_unexpected: got %0h expected none", vid_dat);
          end else begin
            mon_e = vid_q.pop_front();
            check("vid_data", 32'(vid_dat), 32'(mon_e));
            mon_last = mon_e;
            mon_seen = 1'b1;
          end
        end else if (mon_seen) begin
          check("vid_hold", 32'(vid_dat), 32'(mon_last));
        end
        mon_en_prev = vid_en;
      end
    join_none

    fill_model();
    n = 0;
    do begin
      cycle();
      n++;
    end while (busy && n < 5000);
    check("busy_cycles_reset", 32'(n), 32'(FILL));

    xfer(1'b0, 2'b11, 11'h000, 16'h0, EXP_ADR0, 1'b0, lat);
    xfer(1'b0, 2'b11, 11'h7FF, 16'h0, 16'h0720, 1'b0, lat);
`ifdef VGA_TEXT_RAM_BANNER_EN
    xfer(1'b0, 2'b11, 11'd26, 16'h0, 16'h0755, 1'b0, lat);
    xfer(1'b0, 2'b11, 11'd27, 16'h0, 16'h0720, 1'b0, lat);
`endif

    xfer(1'b1, 2'b01, 11'h100, 16'hABCD, 16'h0, 1'b0, lat);
    check("wr_ack_latency", 32'(lat), 32'd1);
    xfer(1'b0, 2'b11, 11'h100, 16'h0, 16'h07CD, 1'b0, lat);
    check("rd_ack_latency", 32'(lat), 32'd1);
    xfer(1'b1, 2'b10, 11'h101, 16'h1234, 16'h0, 1'b0, lat);
    xfer(1'b0, 2'b11, 11'h101, 16'h0, 16'h1220, 1'b0, lat);
    xfer(1'b1, 2'b11, 11'h102, 16'hBEEF, 16'h0, 1'b0, lat);
    xfer(1'b0, 2'b11, 11'h102, 16'h0, 16'hBEEF, 1'b0, lat);
    xfer(1'b1, 2'b00, 11'h103, 16'hFFFF, 16'h0, 1'b0, lat);
    xfer(1'b0, 2'b11, 11'h103, 16'h0, 16'h0720, 1'b0, lat);

    // Video reads collide with CPU writes to the same word: old data expected.
    for (int i = 0; i < 16; i++) begin
      logic [ADDR_W-1:0] a;
      a = 11'h100 + 11'(i);
      vid_en = 1'b1;
      vid_adr = a;
      vid_q.push_back(model[a]);
      if (i % 2 == 0) begin
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 2'b11; wb_adr = a;
        wb_dat_i = 16'h5500 + 16'(i);
        exp_q.push_back(16'h0);
        rd_q.push_back(1'b0);
        model[a] = wb_dat_i;
      end else begin
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      end
      cycle();
    end
    vid_en = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    cycle();

    xfer(1'b0, 2'b11, 11'h100, 16'h0, 16'h5500, 1'b0, lat);
    xfer(1'b0, 2'b11, 11'h101, 16'h0, 16'h1220, 1'b0, lat);
    xfer(1'b0, 2'b11, 11'h10E, 16'h0, 16'h550E, 1'b0, lat);
    xfer(1'b0, 2'b11, 11'h10F, 16'h0, 16'h0720, 1'b0, lat);

    for (int a = 0; a < DEPTH; a++) begin
      vid_en = 1'b1;
      vid_adr = 11'(a);
      vid_q.push_back(model[a]);
      cycle();
    end
    vid_en = 1'b0;
    vid_adr = 11'h005;
    repeat (3) cycle();

    // Restarted fill; video keeps streaming while busy.
    pulse_clr();
    for (int i = 0; i < 100; i++) begin
      vid_en = 1'b1;
      vid_adr = 11'h7FF - 11'(i % 16);
      vid_q.push_back(16'h0720);
      cycle();
    end
    vid_en = 1'b0;
    pulse_clr();
    xfer(1'b0, 2'b11, 11'h7FF, 16'h0, 16'h0720, 1'b0, lat);
    check("stalled_read_latency", 32'(lat), 32'(FILL + 1));

    xfer(1'b1, 2'b11, 11'h200, 16'h1111, 16'h0, 1'b1, lat);
    check("clr_write_latency", 32'(lat), 32'(FILL + 2));
    xfer(1'b0, 2'b11, 11'h200, 16'h0, 16'h1111, 1'b0, lat);
    xfer(1'b0, 2'b11, 11'h100, 16'h0, 16'h0720, 1'b0, lat);
    xfer(1'b0, 2'b11, 11'h000, 16'h0, EXP_ADR0, 1'b0, lat);

    repeat (4) cycle();
    check("bus_queue_drained", 32'(exp_q.size()), 32'd0);
    check("vid_queue_drained", 32'(vid_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
